// File: rtl/conv_temperatura.sv
// conv_temperatura: converts a raw temperature-sensor ADC code into Celsius and
// Fahrenheit integers for the 4-digit display stage. A shift-add multiply
// produces Celsius, then a restoring divide by 5 derives Fahrenheit from it.
// Handshake: a request is taken on any rising edge where dato_valid=1 and the
// FSM is IDLE; listo then pulses for one cycle when new numeroC/numeroF are
// visible. A request seen while busy is dropped and sets the sticky overrun flag.
module conv_temperatura #(
    parameter int ADC_W       = 12,
    parameter int SCALE_NUM   = 330,
    parameter int SCALE_SHIFT = 12,
    parameter int MAX_OUT     = 999
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADC_W-1:0] dato_adc,
    input  logic             dato_valid,
    output logic [9:0]       numeroC,
    output logic [9:0]       numeroF,
    output logic             busy,
    output logic             listo,
    output logic             overrun,
    output logic [1:0]       fsm_state
);

    localparam int ACC_W = ADC_W + 16;

    typedef enum logic [1:0] {IDLE = 2'd0, MULT = 2'd1, DIVF = 2'd2, DONE = 2'd3} state_t;

    state_t           state, state_next;
    logic             busy_d, listo_d;
    logic [5:0]       cnt;
    logic [ADC_W-1:0] mplier;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] acc;
    logic [13:0]      dividend;
    logic [13:0]      quot;
    logic [3:0]       rem;

    logic [ACC_W-1:0] c_raw;
    logic [9:0]       c_sat;
    logic [4:0]       rem_sh;
    logic             q_bit;
    logic [3:0]       rem_next;
    logic [13:0]      f_raw;
    logic [9:0]       f_sat;

    assign fsm_state = state;

    // Saturated Celsius from the finished product, and one restoring-division step.
    always_comb begin
        c_raw    = acc >> SCALE_SHIFT;
        c_sat    = (c_raw > ACC_W'(MAX_OUT)) ? 10'(MAX_OUT) : c_raw[9:0];
        rem_sh   = {rem, dividend[13]};
        q_bit    = (rem_sh >= 5'd5);
        rem_next = q_bit ? 4'(rem_sh - 5'd5) : rem_sh[3:0];
        f_raw    = quot + 14'd32;
        f_sat    = (f_raw > 14'(MAX_OUT)) ? 10'(MAX_OUT) : f_raw[9:0];
    end

    // Next-state logic. DIVF spends its first cycle (cnt==0) loading c*9, then
    // 14 cycles on quotient bits, so listo lands ADC_W+16 edges after acceptance.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (dato_valid) state_next = MULT;
            MULT: if (cnt == 6'(ADC_W - 1)) state_next = DIVF;
            DIVF: if (cnt == 6'd14) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered status outputs.
    always_comb begin
        busy_d  = (state_next != IDLE);
        listo_d = (state == DONE);
    end

    // State register, datapath and output registers; reset discards any work in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            listo    <= 1'b0;
            overrun  <= 1'b0;
            numeroC  <= '0;
            numeroF  <= '0;
            cnt      <= '0;
            mplier   <= '0;
            addend   <= '0;
            acc      <= '0;
            dividend <= '0;
            quot     <= '0;
            rem      <= '0;
        end else begin
            state <= state_next;
            busy  <= busy_d;
            listo <= listo_d;
            if (dato_valid && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (dato_valid) begin
                        mplier <= dato_adc;
                        addend <= ACC_W'(SCALE_NUM);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                MULT: begin
                    if (mplier[0]) acc <= acc + addend;
                    addend <= addend << 1;
                    mplier <= mplier >> 1;
                    cnt    <= (cnt == 6'(ADC_W - 1)) ? 6'd0 : cnt + 6'd1;
                end
                DIVF: begin
                    if (cnt == 6'd0) begin
                        dividend <= {4'd0, c_sat} * 14'd9;
                        rem      <= '0;
                        quot     <= '0;
                    end else begin
                        rem      <= rem_next;
                        dividend <= dividend << 1;
                        quot     <= {quot[12:0], q_bit};
                    end
                    cnt <= cnt + 6'd1;
                end
                DONE: begin
                    numeroC <= c_sat;
                    numeroF <= f_sat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_temperatura.sv
// Bench for conv_temperatura: table-driven conversions through a scoreboard,
// plus sequences for overrun, back-to-back, saturation and mid-conversion reset.
module tb_conv_temperatura;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] dato_adc = '0;
  logic        dato_valid = 1'b0;
  logic [9:0]  numeroC, numeroF, numeroC2, numeroF2;
  logic        busy, listo, overrun, busy2, listo2, overrun2;
  logic [1:0]  fsm_state, fsm_state2;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int accept_cyc;
  int prev_listo_cyc = -1;
  int last_listo_cyc = -1;
  logic [9:0] held_c = '0;
  logic [9:0] held_f = '0;
  logic       listo_d1 = 1'b0;

  logic [19:0] exp_q[$];
  int          lat_q[$];

  typedef struct {
    logic [11:0] adc;
    logic [9:0]  c;
    logic [9:0]  f;
  } vec_t;
  vec_t vecs[7];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  conv_temperatura dut (
    .clk(clk), .reset(reset), .dato_adc(dato_adc), .dato_valid(dato_valid),
    .numeroC(numeroC), .numeroF(numeroF), .busy(busy), .listo(listo),
    .overrun(overrun), .fsm_state(fsm_state)
  );

  conv_temperatura #(.SCALE_NUM(2000)) dut_sat (
    .clk(clk), .reset(reset), .dato_adc(dato_adc), .dato_valid(dato_valid),
    .numeroC(numeroC2), .numeroF(numeroF2), .busy(busy2), .listo(listo2),
    .overrun(overrun2), .fsm_state(fsm_state2)
  );

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference conversion straight from the arithmetic definition.
  function automatic logic [19:0] model(input int adc, input int scale);
    int c, f;
    c = (adc * scale) >>> 12;
    if (c > 999) c = 999;
    f = (c * 9) / 5 + 32;
    if (f > 999) f = 999;
    return {10'(c), 10'(f)};
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [11:0] adc, input logic [19:0] exp_cf);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    if (busy) check("send_wait_idle", 1, 0);
    dato_adc   = adc;
    dato_valid = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(exp_cf);
    lat_q.push_back(cyc);
    @(negedge clk);
    dato_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("wait_done_timeout", exp_q.size(), 0);
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge clk);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [19:0] e;
    int t;
    if (!reset) begin
      held_c   = '0;
      held_f   = '0;
      listo_d1 = 1'b0;
    end else begin
      if (listo && listo_d1) check("listo_one_cycle", 1, 0);
      if (listo) begin
        prev_listo_cyc = last_listo_cyc;
        last_listo_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_listo", 1, 0);
        end else begin
          e = exp_q.pop_front();
          t = lat_q.pop_front();
          check("numeroC", numeroC, e[19:10]);
          check("numeroF", numeroF, e[9:0]);
          check("latency", cyc - t, 28);
        end
        held_c = numeroC;
        held_f = numeroF;
      end else if (numeroC !== held_c || numeroF !== held_f) begin
        check("outputs_hold", {numeroC, numeroF}, {held_c, held_f});
        held_c = numeroC;
        held_f = numeroF;
      end
      listo_d1 = listo;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    logic [11:0] r;

    vecs[0] = '{12'd0,    10'd0,   10'd32};
    vecs[1] = '{12'd1241, 10'd99,  10'd210};
    vecs[2] = '{12'd2048, 10'd165, 10'd329};
    vecs[3] = '{12'd4095, 10'd329, 10'd624};
    vecs[4] = '{12'd1,    10'd0,   10'd32};
    vecs[5] = '{12'd13,   10'd1,   10'd33};
    vecs[6] = '{12'd3000, 10'd241, 10'd465};

    // Reset state, with a request held high during reset: must not be taken.
    dato_valid = 1'b1;
    dato_adc   = 12'd2048;
    repeat (3) @(negedge clk);
    dato_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rst_numeroC", numeroC, 0);
    check("rst_numeroF", numeroF, 0);
    check("rst_busy", busy, 0);
    check("rst_listo", listo, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", fsm_state, 0);

    // Table vectors, issued back to back.
    for (int i = 0; i < 7; i++) send(vecs[i].adc, {vecs[i].c, vecs[i].f});
    wait_done();

    // Random codes against the reference model.
    for (int i = 0; i < 6; i++) begin
      r = 12'($urandom_range(0, 4095));
      send(r, model(r, 330));
    end
    wait_done();
    check("no_overrun_yet", overrun, 0);

    // Request re-asserted while busy: dropped, overrun set, first result kept.
    send(12'd1241, {10'd99, 10'd210});
    repeat (3) @(negedge clk);
    check("busy_mid", busy, 1);
    dato_adc   = 12'd4095;
    dato_valid = 1'b1;
    @(negedge clk);
    dato_valid = 1'b0;
    check("overrun_set", overrun, 1);
    wait_done();
    send(12'd2048, {10'd165, 10'd329});
    wait_done();
    check("overrun_sticky", overrun, 1);

    // Back-to-back: second request on the edge after listo.
    send(12'd3000, {10'd241, 10'd465});
    send(12'd13, {10'd1, 10'd33});
    wait_done();
    check("b2b_spacing", last_listo_cyc - prev_listo_cyc, 29);

    // Saturation on the SCALE_NUM=2000 instance.
    send(12'd4095, {10'd329, 10'd624});
    n = 0;
    while (!listo2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("sat_listo_seen", listo2, 1);
    check("sat_numeroC", numeroC2, 999);
    check("sat_numeroF", numeroF2, 999);
    wait_done();

    // Reset held low 3 cycles in the middle of MULT.
    send(12'd1241, {10'd99, 10'd210});
    repeat (4) @(negedge clk);
    check("pre_rst_state", fsm_state, 1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    lat_q.delete();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_numeroC", numeroC, 0);
    check("mid_rst_numeroF", numeroF, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_listo", listo, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_state", fsm_state, 0);
    repeat (35) @(negedge clk);
    check("post_rst_idle", busy, 0);

    // One more conversion after reset to confirm normal operation resumes.
    send(12'd2048, {10'd165, 10'd329});
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
